// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath widths and writeback arbiter state encoding
package cpu_pkg;
    localparam int DATA_W = 8;
    localparam int REG_W  = 3;
    typedef enum logic [1:0] {IDLE, DRAIN, FORCE} wb_arb_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: sync FIFO holding matrix results (data + destination register)
// Ports: i_push/i_pop request enqueue/dequeue (ignored when full/empty),
//        i_data/i_dest entry in, o_data/o_dest head entry (0 when empty),
//        o_count occupancy, o_full/o_empty status.
module wb_fifo #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DATA_W-1:0]          i_data,
    input  logic [REG_W-1:0]           i_dest,
    output logic [DATA_W-1:0]          o_data,
    output logic [REG_W-1:0]           o_dest,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [REG_W-1:0]  r_dest [DEPTH];
    logic [AW-1:0]     r_wr, r_rd;
    logic [AW:0]       r_count;
    logic              w_wr_en, w_rd_en;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_data[r_rd];
    assign o_dest  = o_empty ? '0 : r_dest[r_rd];
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_data[r_wr] <= i_data;
            r_dest[r_wr] <= i_dest;
        end
    end
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + AW'(1);
            if (w_rd_en) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(w_wr_en) - (AW+1)'(w_rd_en);
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between pipeline WB and matrix unit
// Ports: pipe_write pipeline write request; mx_valid/mx_data/mx_dest matrix result in,
//        mx_ready back-pressure; wb_sel/mx_wrtdata/mx_destreg/mx_write to the WB mux;
//        pipe_stall to hazard unit; fifo_count buffer occupancy.
module wb_arbiter #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int REG_W    = cpu_pkg::REG_W,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_write,
    input  logic                   mx_valid,
    input  logic [DATA_W-1:0]      mx_data,
    input  logic [REG_W-1:0]       mx_dest,
    output logic                   mx_ready,
    output logic                   wb_sel,
    output logic [DATA_W-1:0]      mx_wrtdata,
    output logic [REG_W-1:0]       mx_destreg,
    output logic                   mx_write,
    output logic                   pipe_stall,
    output logic [$clog2(DEPTH):0] fifo_count
);
    import cpu_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    wb_arb_state_t r_state, w_next;
    logic [WW-1:0] r_wait, w_wait_nx;
    logic [CW-1:0] w_count_nx;
    logic          w_full, w_empty, w_push, w_pop;
    assign mx_ready   = !w_full;
    assign w_push     = mx_valid && !w_full;
    // DRAIN yields to the pipeline; FORCE takes the port regardless.
    assign w_pop      = !w_empty && (r_state == FORCE || (r_state == DRAIN && !pipe_write));
    assign wb_sel     = w_pop;
    assign mx_write   = w_pop;
    assign pipe_stall = r_state == FORCE && pipe_write;
    assign w_count_nx = fifo_count + CW'(w_push) - CW'(w_pop);
    assign w_wait_nx  = (r_state == DRAIN && !w_pop) ? r_wait + WW'(1) : '0;
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_push ? DRAIN : IDLE;
            DRAIN:   w_next = w_count_nx == '0 ? IDLE : (w_wait_nx == WW'(MAX_WAIT) ? FORCE : DRAIN);
            FORCE:   w_next = w_count_nx == '0 ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nx;
        end
    end
    wb_fifo #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (mx_data),
        .i_dest  (mx_dest),
        .o_data  (mx_wrtdata),
        .o_dest  (mx_destreg),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    import cpu_pkg::*;
    logic       clk = 1'b0;
    logic       rst, pipe_write, mx_valid;
    logic [7:0] mx_data;
    logic [2:0] mx_dest;
    logic       mx_ready, wb_sel, mx_write, pipe_stall;
    logic [7:0] mx_wrtdata;
    logic [2:0] mx_destreg;
    logic [2:0] fifo_count;
    int n_checks = 0;
    int n_fail = 0;
    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_write (pipe_write),
        .mx_valid   (mx_valid),
        .mx_data    (mx_data),
        .mx_dest    (mx_dest),
        .mx_ready   (mx_ready),
        .wb_sel     (wb_sel),
        .mx_wrtdata (mx_wrtdata),
        .mx_destreg (mx_destreg),
        .mx_write   (mx_write),
        .pipe_stall (pipe_stall),
        .fifo_count (fifo_count)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push_val(input logic [7:0] d);
        mx_data = d;
        mx_dest = d[2:0];
    endtask
    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ready"}, 32'(mx_ready), 1);
        chk({tag, "_sel"}, 32'(wb_sel), 0);
        chk({tag, "_write"}, 32'(mx_write), 0);
        chk({tag, "_data"}, 32'(mx_wrtdata), 0);
        chk({tag, "_dest"}, 32'(mx_destreg), 0);
        chk({tag, "_stall"}, 32'(pipe_stall), 0);
        chk({tag, "_count"}, 32'(fifo_count), 0);
    endtask
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        rst = 1'b1; pipe_write = 1'b0; mx_valid = 1'b1; push_val(8'h3C); mx_dest = 3'd5;
        step(); step();
        chk_idle_outs("rst_hold");
        rst = 1'b0;
        step();
        mx_valid = 1'b0;
        chk("rel_count", 32'(fifo_count), 1);
        chk("rel_data", 32'(mx_wrtdata), 32'h3C);
        chk("rel_dest", 32'(mx_destreg), 5);
        chk("rel_state", 32'(dut.r_state), 32'(DRAIN));
        step();
        chk("rel_empty", 32'(fifo_count), 0);
        chk("rel_idle", 32'(dut.r_state), 32'(IDLE));
        mx_valid = 1'b1; mx_data = 8'hA5; mx_dest = 3'd3;
        step();
        mx_valid = 1'b0;
        chk("a5_sel", 32'(wb_sel), 1);
        chk("a5_write", 32'(mx_write), 1);
        chk("a5_dest", 32'(mx_destreg), 3);
        chk("a5_data", 32'(mx_wrtdata), 32'hA5);
        step();
        chk("a5_count", 32'(fifo_count), 0);
        chk("a5_nowrite", 32'(mx_write), 0);
        pipe_write = 1'b1; mx_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push_val(8'(i));
            step();
            chk("fill_count", 32'(fifo_count), 32'(i));
            chk("fill_sel", 32'(wb_sel), 0);
            chk("fill_stall", 32'(pipe_stall), 0);
        end
        push_val(8'h04);
        step();
        push_val(8'h05);
        chk("e4_count", 32'(fifo_count), 4);
        chk("e4_ready", 32'(mx_ready), 0);
        chk("e4_stall", 32'(pipe_stall), 1);
        chk("e4_sel", 32'(wb_sel), 1);
        chk("e4_write", 32'(mx_write), 1);
        chk("e4_data", 32'(mx_wrtdata), 32'h01);
        chk("e4_dest", 32'(mx_destreg), 1);
        step();
        chk("e5_count", 32'(fifo_count), 3);
        chk("e5_ready", 32'(mx_ready), 1);
        chk("e5_sel", 32'(wb_sel), 0);
        chk("e5_stall", 32'(pipe_stall), 0);
        chk("e5_data", 32'(mx_wrtdata), 32'h02);
        step();
        push_val(8'h06);
        chk("e6_count", 32'(fifo_count), 4);
        chk("e6_ready", 32'(mx_ready), 0);
        chk("e6_data", 32'(mx_wrtdata), 32'h02);
        step();
        chk("e7_count", 32'(fifo_count), 4);
        chk("e7_sel", 32'(wb_sel), 0);
        step();
        chk("e8_count", 32'(fifo_count), 4);
        chk("e8_stall", 32'(pipe_stall), 1);
        chk("e8_write", 32'(mx_write), 1);
        chk("e8_data", 32'(mx_wrtdata), 32'h02);
        step();
        chk("e9_count", 32'(fifo_count), 3);
        chk("e9_data", 32'(mx_wrtdata), 32'h03);
        step();
        push_val(8'h07);
        chk("e10_count", 32'(fifo_count), 4);
        chk("e10_sel", 32'(wb_sel), 0);
        chk("e10_data", 32'(mx_wrtdata), 32'h03);
        pipe_write = 1'b0;
        #1;
        chk("drain_sel", 32'(wb_sel), 1);
        for (int i = 11; i <= 17; i++) begin
            step();
            if (i >= 12 && i <= 14) push_val(8'(i - 4));
            if (i == 15) mx_valid = 1'b0;
            chk("wrap_data", 32'(mx_wrtdata), 32'(i - 7));
            chk("wrap_dest", 32'(mx_destreg), 32'((i - 7) % 8));
            chk("wrap_count", 32'(fifo_count), i <= 15 ? 3 : 32'(18 - i));
            chk("wrap_write", 32'(mx_write), 1);
        end
        step();
        chk("wrap_empty", 32'(fifo_count), 0);
        chk("wrap_idle", 32'(dut.r_state), 32'(IDLE));
        chk("wrap_nowrite", 32'(mx_write), 0);
        pipe_write = 1'b1; mx_valid = 1'b1; push_val(8'h55);
        step();
        push_val(8'h66);
        step();
        mx_valid = 1'b0;
        chk("pre_arst_count", 32'(fifo_count), 2);
        #2 rst = 1'b1;
        #1;
        chk_idle_outs("arst");
        pipe_write = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_arst_write", 32'(mx_write), 0);
            chk("post_arst_count", 32'(fifo_count), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
